// File: rtl/dual_bus_trigger_ctrl.sv
// Push-button run controller: synchronises and debounces the button and mode switch, then
// issues one bounded trigger/start run per clean press. Timeouts and completed runs are tracked.
module dual_bus_trigger_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES   = 16,
  parameter int unsigned TRIG_PULSE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_raw_i,
  input  logic       mode_sw_i,
  input  logic       demo_ready_i,
  output logic       btn_trigger_o,
  output logic       demo_start_o,
  output logic       demo_mode_o,
  output logic       busy_o,
  output logic       timeout_err_o,
  output logic [7:0] run_count_o
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PwW = $clog2(TRIG_PULSE_CYCLES + 1);
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PwW-1:0] PwLast = PwW'(TRIG_PULSE_CYCLES - 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPulse, StWaitAck, StWaitDone} state_e;

  logic           btn_s1_q, btn_s2_q, mode_s1_q, mode_s2_q;
  logic           stable_q, stable_d, stable_prev_q, press_q;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  state_e         state_q, state_d;
  logic [PwW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           mode_q, mode_d, err_q, err_d;
  logic [7:0]     count_q, count_d;

  // Stable level only follows s2 after DEBOUNCE_CYCLES consecutive differing cycles.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    if (btn_s2_q != stable_q) begin
      if (db_cnt_q == DbLast) begin
        stable_d = btn_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    to_cnt_d    = to_cnt_q;
    mode_d      = mode_q;
    err_d       = err_q;
    count_d     = count_q;
    unique case (state_q)
      StIdle: begin
        if (press_q) begin
          mode_d      = mode_s2_q;
          err_d       = 1'b0;
          pulse_cnt_d = '0;
          state_d     = StPulse;
        end
      end
      StPulse: begin
        if (pulse_cnt_q == PwLast) begin
          to_cnt_d = '0;
          state_d  = StWaitAck;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
      end
      // Ready transitions are checked before the timeout so they win a tie.
      StWaitAck: begin
        if (!demo_ready_i) begin
          to_cnt_d = to_cnt_q + 1'b1;
          state_d  = StWaitDone;
        end else if (to_cnt_q == ToLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (demo_ready_i) begin
          count_d = count_q + 8'd1;
          state_d = StIdle;
        end else if (to_cnt_q == ToLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_s1_q      <= 1'b0;
      btn_s2_q      <= 1'b0;
      mode_s1_q     <= 1'b0;
      mode_s2_q     <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      press_q       <= 1'b0;
      db_cnt_q      <= '0;
      state_q       <= StIdle;
      pulse_cnt_q   <= '0;
      to_cnt_q      <= '0;
      mode_q        <= 1'b0;
      err_q         <= 1'b0;
      count_q       <= 8'd0;
    end else begin
      btn_s1_q      <= btn_raw_i;
      btn_s2_q      <= btn_s1_q;
      mode_s1_q     <= mode_sw_i;
      mode_s2_q     <= mode_s1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      press_q       <= stable_q & ~stable_prev_q;
      db_cnt_q      <= db_cnt_d;
      state_q       <= state_d;
      pulse_cnt_q   <= pulse_cnt_d;
      to_cnt_q      <= to_cnt_d;
      mode_q        <= mode_d;
      err_q         <= err_d;
      count_q       <= count_d;
    end
  end

  assign btn_trigger_o = (state_q == StPulse);
  assign demo_start_o  = (state_q == StPulse) && (pulse_cnt_q == '0);
  assign busy_o        = (state_q != StIdle);
  assign demo_mode_o   = mode_q;
  assign timeout_err_o = err_q;
  assign run_count_o   = count_q;

endmodule

// File: tb/tb_dual_bus_trigger_ctrl.sv
// Scoreboarded bench: each scheduled run pushes its expected outcome; a monitor checks each
// completed run (busy falling) against the queue head.
module tb_dual_bus_trigger_ctrl;

  localparam int unsigned D  = 16;
  localparam int unsigned TP = 4;
  localparam int unsigned TO = 1024;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       btn_raw = 1'b0, mode_sw = 1'b0, demo_ready = 1'b1;
  logic       btn_trigger, demo_start, demo_mode, busy, timeout_err;
  logic [7:0] run_count;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int cnt_m = 0;

  typedef struct {
    int start;
    int fin;
    bit mode;
    bit err;
    int count;
  } exp_t;
  exp_t q[$];

  dual_bus_trigger_ctrl #(
    .DEBOUNCE_CYCLES  (D),
    .TRIG_PULSE_CYCLES(TP),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .btn_raw_i    (btn_raw),
    .mode_sw_i    (mode_sw),
    .demo_ready_i (demo_ready),
    .btn_trigger_o(btn_trigger),
    .demo_start_o (demo_start),
    .demo_mode_o  (demo_mode),
    .busy_o       (busy),
    .timeout_err_o(timeout_err),
    .run_count_o  (run_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: measures each run and compares it with the oldest expectation.
  initial begin
    bit   trig_prev, busy_prev;
    int   t_start, t_w, n_start;
    exp_t e;
    trig_prev = 0; busy_prev = 0; t_start = 0; t_w = 0; n_start = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        trig_prev = 0;
        busy_prev = 0;
      end else begin
        if (btn_trigger && !trig_prev) begin
          t_start = cyc; t_w = 0; n_start = 0;
          check("err_cleared_at_press", timeout_err, 0);
        end
        if (btn_trigger) t_w++;
        if (demo_start) n_start++;
        if (busy_prev && !busy) begin
          check("run_expected", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check("trig_start_cycle", t_start, e.start);
            check("trig_width", t_w, TP);
            check("start_pulses", n_start, 1);
            check("demo_mode", demo_mode, e.mode);
            check("timeout_err", timeout_err, e.err);
            check("run_count", run_count, e.count);
            check("run_end_cycle", cyc, e.fin);
          end
        end
        trig_prev = btn_trigger;
        busy_prev = busy;
      end
    end
  end

  // One run: press held 'hold' cycles; ready low for 'low' cycles starting 'drop' cycles after
  // WAIT_ACK entry (or held high for a timeout); optional second press window and mode toggle
  // relative to WAIT_ACK entry.
  task automatic run_one(input int hold, input bit mode, input int drop, input int low,
                         input bit tmo, input int p2s, input int p2e, input int mtog);
    int   c, w, fin, total, t;
    exp_t e;
    mode_sw = mode;
    repeat (3) @(negedge clk);
    c   = cyc;
    w   = c + D + 8;
    fin = tmo ? w + TO : w + drop + low + 1;
    if (!tmo) cnt_m = (cnt_m + 1) % 256;
    e.start = c + D + 4; e.fin = fin; e.mode = mode; e.err = tmo; e.count = cnt_m;
    q.push_back(e);
    total = fin - c;
    if (hold > total) total = hold;
    if (w - c + p2e > total) total = w - c + p2e;
    total += 2 * D + 10;
    for (int k = 0; k < total; k++) begin
      t = c + k;
      btn_raw    = (k < hold) || (t >= w + p2s && t < w + p2e);
      demo_ready = tmo || !(t >= w + drop && t < w + drop + low);
      if (mtog >= 0 && t == w + mtog) mode_sw = ~mode;
      @(negedge clk);
    end
    btn_raw    = 1'b0;
    demo_ready = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, n;
    repeat (3) @(negedge clk);
    check("rst_btn_trigger", btn_trigger, 0);
    check("rst_demo_start", demo_start, 0);
    check("rst_demo_mode", demo_mode, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_run_count", run_count, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_one(100, 1'b1, 3, 10, 1'b0, 0, 0, -1);

    // Bounce: 15-cycle highs separated by 2-cycle lows never qualify.
    nb = 0;
    for (int g = 0; g < 6; g++) begin
      for (int k = 0; k < 17; k++) begin
        btn_raw = (k < 15);
        @(negedge clk);
        if (busy || btn_trigger) nb++;
      end
    end
    btn_raw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy || btn_trigger) nb++;
    end
    check("bounce_no_activity", nb, 0);

    run_one(25, 1'b0, 0, 0, 1'b1, 0, 0, -1);
    run_one(25, 1'b1, 2, 5, 1'b0, 0, 0, -1);
    run_one(22, 1'b1, 2, 60, 1'b0, 20, 50, 5);

    n = 256 - cnt_m;
    for (int i = 0; i < n; i++) begin
      run_one($urandom_range(30, 20), 1'($urandom_range(1, 0)), $urandom_range(5, 0),
              $urandom_range(8, 1), 1'b0, 0, 0, -1);
    end
    check("run_count_wrapped", run_count, 0);

    // Reset in the middle of a pulse.
    mode_sw = 1'b1;
    repeat (3) @(negedge clk);
    btn_raw = 1'b1;
    repeat (D + 5) @(negedge clk);
    check("mid_pulse_trigger", btn_trigger, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_btn_trigger", btn_trigger, 0);
    check("arst_demo_start", demo_start, 0);
    check("arst_demo_mode", demo_mode, 0);
    check("arst_busy", busy, 0);
    check("arst_timeout_err", timeout_err, 0);
    check("arst_run_count", run_count, 0);
    btn_raw = 1'b0;
    cnt_m   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    nb = 0;
    repeat (80) begin
      @(negedge clk);
      if (busy || btn_trigger) nb++;
    end
    check("post_reset_no_pulse", nb, 0);
    check("post_reset_run_count", run_count, cnt_m);
    check("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
